obi_rr_arbiter: RTL and testbench
=================================

Name: obi_rr_arbiter

Overview:
- Shares one downstream OBI port between two OBI requesters: port 0 is core instruction fetch, port 1 is core LSU.
- The downstream port feeds the OBI-to-AXI bridge in the FPGA top level.
- Grants are round-robin, with request hold while the downstream port stalls.
- The owner of each accepted transaction is tracked in an in-order ID FIFO so responses return to the correct requester.
- The number of in-flight transactions is bounded.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports; byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered transactions; power of two, 1..16.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- m0_req_i  in  1  port-0 request.
- m0_gnt_o  out  1  port-0 grant.
- m0_rvalid_o  out  1  port-0 response valid.
- m0_we_i  in  1  port-0 write enable.
- m0_be_i  in  DATA_WIDTH/8  port-0 byte enables.
- m0_addr_i  in  ADDR_WIDTH  port-0 address.
- m0_wdata_i  in  DATA_WIDTH  port-0 write data.
- m0_rdata_o  out  DATA_WIDTH  port-0 read data.
- m1_*: the same eight signals as m0_*, for port 1.
- s_req_o  out  1  downstream request.
- s_gnt_i  in  1  downstream grant.
- s_rvalid_i  in  1  downstream response valid.
- s_we_o  out  1  downstream write enable.
- s_be_o  out  DATA_WIDTH/8  downstream byte enables.
- s_addr_o  out  ADDR_WIDTH  downstream address.
- s_wdata_o  out  DATA_WIDTH  downstream write data.
- s_rdata_i  in  DATA_WIDTH  downstream read data.
- resp_err_o  out  1  sticky flag: a response arrived with no transaction outstanding.

Behaviour:
- Reset:
  - While rst_i is high, all gnt/rvalid outputs and s_req_o are 0, independent of inputs.
  - On reset: ID FIFO emptied, outstanding count = 0, priority pointer = port 0, lock cleared, resp_err_o = 0.
  - Reset mid-transaction discards all tracking; responses arriving after reset set resp_err_o.
- Downstream contract: s_rvalid_i is asserted exactly once per granted transaction (reads and writes), in grant order, earliest in the cycle after the grant.
- Selection is combinational in the same cycle:
  - The chosen port's req/we/be/addr/wdata drive s_*.
  - s_req_o = chosen req AND (outstanding < MAX_OUTSTANDING).
  - Chosen m*_gnt_o = s_gnt_i AND s_req_o; the other port's gnt is 0.
- Arbitration states:
  - IDLE:
    - If only one port requests, choose it.
    - If both request, choose the port indicated by the priority pointer.
  - LOCKED: entered when s_req_o=1 and s_gnt_i=0; the selection is frozen to the same port until a grant occurs.
    - The other port's request cannot steal the grant.
    - A requester dropping req while locked is an OBI violation and is not supported.
  - On any grant: the priority pointer moves to the other port; next state is IDLE.
- Full case:
  - When outstanding == MAX_OUTSTANDING, s_req_o = 0 and no grants are issued.
  - The selection is not locked while full.
  - A response arriving in the same cycle as a full condition does not free a slot until the next cycle (registered count).
- ID FIFO:
  - Depth MAX_OUTSTANDING, width 1.
  - Push the granted port ID on each downstream grant; pop on s_rvalid_i.
  - Simultaneous push and pop in one cycle is legal; the count is unchanged.
  - Read/write pointers wrap modulo depth.
- Responses:
  - On s_rvalid_i, the FIFO head selects the port; that m*_rvalid_o = 1 in the same cycle and m*_rdata_o = s_rdata_i.
  - Both rdata outputs always carry s_rdata_i.
  - The non-owner's rvalid is 0.
- Empty case: s_rvalid_i with the FIFO empty produces no rvalid on either port, sets resp_err_o (held until reset), and leaves the count unchanged.
- Latency: grant is zero-cycle (combinational through); the response path is zero added cycles.

Decomposition:
- Package obi_rr_arbiter_pkg:
  - port_id_t (1-bit logic)
  - arbiter state enum {ARB_IDLE, ARB_LOCKED}
  - localparam helper for the count width $clog2(MAX_OUTSTANDING)+1
- Sub-module obi_id_fifo:
  - Parameterised depth.
  - Ports: push/pop/id_in/id_out/empty/full/count.
  - Reused by future multi-port arbiters.

Test Plan:
- Single requester: port 0 issues 4 back-to-back reads at 0x100..0x10C, s_gnt_i=1, responses 1 cycle later with rdata 0xA0..0xA3 -> m0_rvalid_o pulses 4 times with matching data; m1_rvalid_o stays 0.
- Contention: both ports request continuously with s_gnt_i=1 -> grants alternate 0,1,0,1 starting with port 0 after reset; responses route in the same order.
- Stall lock: port 1 selected, s_gnt_i=0 for 3 cycles while port 0 raises req -> s_addr_o stays port 1's address; port 1 is granted on the 4th cycle; port 0 is granted next.
- Full: MAX_OUTSTANDING=4, 4 grants with no response -> s_req_o=0 with both reqs high; one s_rvalid_i -> s_req_o returns to 1 the following cycle.
- Simultaneous push/pop: grant and response in the same cycle at count=2 -> count stays 2; order is preserved.
- Spurious response / reset: s_rvalid_i with FIFO empty -> no m*_rvalid_o, resp_err_o=1 until rst_i. Assert rst_i with 3 outstanding -> count 0, pointer = port 0, all outputs 0 in the following cycle.

Source files
------------

// File: rtl/obi_rr_arbiter_pkg.sv
// Shared types and sizing helpers for the two-port OBI round-robin arbiter
// and its in-order owner-ID FIFO.
package obi_rr_arbiter_pkg;

  typedef logic port_id_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // Count must represent 0..MAX inclusive, hence the extra bit.
  function automatic int cnt_width(input int max_outstanding);
    return $clog2(max_outstanding) + 1;
  endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// In-order FIFO of requester IDs: one entry per accepted transaction, popped
// as responses return so each response is steered to its owner.
module obi_id_fifo
  import obi_rr_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  port_id_t         id_i,
  output port_id_t         id_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  port_id_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign id_o    = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= id_i;
    end
  end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Two-to-one OBI arbiter (port 0 = fetch, port 1 = LSU) with round-robin
// priority, stall locking and in-order response routing.
module obi_rr_arbiter
  import obi_rr_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    s_req_o,
  input  logic                    s_gnt_i,
  input  logic                    s_rvalid_i,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  output logic                    resp_err_o
);

  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

  arb_state_e       state_q, state_d;
  port_id_t         prio_q, prio_d;
  port_id_t         lock_port_q, lock_port_d;
  logic             resp_err_q, resp_err_d;
  port_id_t         sel;
  port_id_t         head_id;
  logic             sel_req, grant, push, pop;
  logic             fifo_empty, fifo_full;
  logic [CNT_W-1:0] outstanding;

  // A stalled request keeps its port; otherwise a lone requester wins and a
  // tie goes to the priority pointer.
  always_comb begin
    if (state_q == ARB_LOCKED) begin
      sel = lock_port_q;
    end else if (m0_req_i != m1_req_i) begin
      sel = m1_req_i;
    end else begin
      sel = prio_q;
    end
  end

  assign sel_req   = sel ? m1_req_i : m0_req_i;
  assign s_req_o   = !rst_i && sel_req && (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign s_we_o    = sel ? m1_we_i : m0_we_i;
  assign s_be_o    = sel ? m1_be_i : m0_be_i;
  assign s_addr_o  = sel ? m1_addr_i : m0_addr_i;
  assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

  assign grant    = s_req_o && s_gnt_i;
  assign m0_gnt_o = grant && (sel == 1'b0);
  assign m1_gnt_o = grant && (sel == 1'b1);

  assign push = grant && !fifo_full;
  assign pop  = !rst_i && s_rvalid_i && !fifo_empty;

  assign m0_rvalid_o = pop && (head_id == 1'b0);
  assign m1_rvalid_o = pop && (head_id == 1'b1);
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;
  assign resp_err_o  = resp_err_q;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    lock_port_d = lock_port_q;
    if (grant) begin
      state_d = ARB_IDLE;
      prio_d  = ~sel;
    end else if (s_req_o) begin
      state_d     = ARB_LOCKED;
      lock_port_d = sel;
    end
    resp_err_d = resp_err_q || (s_rvalid_i && fifo_empty);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      prio_q      <= 1'b0;
      lock_port_q <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      lock_port_q <= lock_port_d;
      resp_err_q  <= resp_err_d;
    end
  end

  obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .id_i    (sel),
    .id_o    (head_id),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (outstanding)
  );

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Self-checking bench for obi_rr_arbiter: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_obi_rr_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req_i = 1'b0, m1_req_i = 1'b0;
  logic          m0_we_i = 1'b0, m1_we_i = 1'b1;
  logic [DW/8-1:0] m0_be_i = 4'hF, m1_be_i = 4'h3;
  logic [AW-1:0] m0_addr_i = '0, m1_addr_i = '0;
  logic [DW-1:0] m0_wdata_i = '0, m1_wdata_i = '0;
  logic          s_gnt_i = 1'b0, s_rvalid_i = 1'b0;
  logic [DW-1:0] s_rdata_i = '0;
  logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          s_req_o, s_we_o, resp_err_o;
  logic [DW/8-1:0] s_be_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_wdata_o;

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  always #5 clk = ~clk;

  obi_rr_arbiter #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .m0_req_i    (m0_req_i),
    .m0_gnt_o    (m0_gnt_o),
    .m0_rvalid_o (m0_rvalid_o),
    .m0_we_i     (m0_we_i),
    .m0_be_i     (m0_be_i),
    .m0_addr_i   (m0_addr_i),
    .m0_wdata_i  (m0_wdata_i),
    .m0_rdata_o  (m0_rdata_o),
    .m1_req_i    (m1_req_i),
    .m1_gnt_o    (m1_gnt_o),
    .m1_rvalid_o (m1_rvalid_o),
    .m1_we_i     (m1_we_i),
    .m1_be_i     (m1_be_i),
    .m1_addr_i   (m1_addr_i),
    .m1_wdata_i  (m1_wdata_i),
    .m1_rdata_o  (m1_rdata_o),
    .s_req_o     (s_req_o),
    .s_gnt_i     (s_gnt_i),
    .s_rvalid_i  (s_rvalid_i),
    .s_we_o      (s_we_o),
    .s_be_o      (s_be_o),
    .s_addr_o    (s_addr_o),
    .s_wdata_o   (s_wdata_o),
    .s_rdata_i   (s_rdata_i),
    .resp_err_o  (resp_err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owners of accepted transactions in a queue, a pointer
  // naming who wins a tie, and a remembered stalled request.
  int owners[$];
  bit prio_m = 0, stalled_m = 0, stall_port_m = 0, err_m = 0;
  bit sel_m, req_sel, e_sreq, e_rv;

  always @(negedge clk) begin
    if (started) begin
      if (stalled_m) sel_m = stall_port_m;
      else if (m0_req_i && !m1_req_i) sel_m = 0;
      else if (m1_req_i && !m0_req_i) sel_m = 1;
      else sel_m = prio_m;
      req_sel = sel_m ? m1_req_i : m0_req_i;
      e_sreq  = !rst && req_sel && (owners.size() < MAXO);
      e_rv    = !rst && s_rvalid_i && (owners.size() > 0);

      chk("model_s_req", 32'(s_req_o), 32'(e_sreq));
      chk("model_m0_gnt", 32'(m0_gnt_o), 32'(e_sreq && s_gnt_i && !sel_m));
      chk("model_m1_gnt", 32'(m1_gnt_o), 32'(e_sreq && s_gnt_i && sel_m));
      chk("model_m0_rvalid", 32'(m0_rvalid_o), 32'(e_rv && owners[0] == 0));
      chk("model_m1_rvalid", 32'(m1_rvalid_o), 32'(e_rv && owners[0] == 1));
      chk("model_m0_rdata", m0_rdata_o, s_rdata_i);
      chk("model_m1_rdata", m1_rdata_o, s_rdata_i);
      chk("model_resp_err", 32'(resp_err_o), 32'(err_m));
      if (e_sreq) begin
        chk("model_s_addr", s_addr_o, sel_m ? m1_addr_i : m0_addr_i);
        chk("model_s_wdata", s_wdata_o, sel_m ? m1_wdata_i : m0_wdata_i);
        chk("model_s_we", 32'(s_we_o), 32'(sel_m ? m1_we_i : m0_we_i));
        chk("model_s_be", 32'(s_be_o), 32'(sel_m ? m1_be_i : m0_be_i));
      end

      if (rst) begin
        owners.delete();
        prio_m = 0; stalled_m = 0; err_m = 0;
      end else begin
        if (s_rvalid_i && owners.size() == 0) err_m = 1;
        if (e_rv) void'(owners.pop_front());
        if (e_sreq && s_gnt_i) begin
          owners.push_back(int'(sel_m));
          prio_m = !sel_m;
          stalled_m = 0;
        end else if (e_sreq) begin
          stalled_m = 1;
          stall_port_m = sel_m;
        end
      end
    end
  end

  // One clock of stimulus; returns just after the falling edge so callers
  // can inspect the combinational outputs for that cycle.
  task automatic cyc(input bit r, input bit r0, input logic [31:0] a0,
                     input bit r1, input logic [31:0] a1,
                     input bit g, input bit rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    rst = r;
    m0_req_i = r0; m0_addr_i = a0; m0_wdata_i = a0 ^ 32'h5A5A_0000;
    m1_req_i = r1; m1_addr_i = a1; m1_wdata_i = ~a1;
    s_gnt_i = g; s_rvalid_i = rv; s_rdata_i = rd;
    started = 1;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, n1;

    // Reset with requests and a grant present: nothing may leak out.
    cyc(1, 1, 32'h10, 1, 32'h20, 1, 1, 32'h1);
    chk("rst_s_req", 32'(s_req_o), 0);
    chk("rst_gnt", 32'({m1_gnt_o, m0_gnt_o}), 0);
    chk("rst_rvalid", 32'({m1_rvalid_o, m0_rvalid_o}), 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_resp_err", 32'(resp_err_o), 0);

    // Single requester: four back-to-back reads, responses one cycle later.
    n0 = 0; n1 = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, i < 4, 32'h100 + 32'(4 * i), 0, 0, 1, i > 0, 32'hA0 + 32'(i) - 1);
      if (i < 4) chk("single_addr", s_addr_o, 32'h100 + 32'(4 * i));
      if (m0_rvalid_o) begin
        chk("single_rdata", m0_rdata_o, 32'hA0 + 32'(n0));
        n0++;
      end
      if (m1_rvalid_o) n1++;
    end
    chk("single_m0_pulses", 32'(n0), 4);
    chk("single_m1_pulses", 32'(n1), 0);

    // Contention right after reset: grants alternate starting with port 0.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 32'h200 + 32'(i), 1, 32'h300 + 32'(i), 1, i > 0, 32'hC0 + 32'(i));
      chk("contend_gnt", 32'({m1_gnt_o, m0_gnt_o}), (i % 2) ? 2 : 1);
      if (i > 0) chk("contend_rvalid", 32'({m1_rvalid_o, m0_rvalid_o}), ((i - 1) % 2) ? 2 : 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hC4);
    chk("contend_last_rvalid", 32'({m1_rvalid_o, m0_rvalid_o}), 2);

    // Stall lock: port 1 stalls, port 0 joins, port 1 must keep the bus.
    cyc(0, 0, 0, 1, 32'h400, 0, 0, 0);
    chk("lock_sel1", s_addr_o, 32'h400);
    cyc(0, 1, 32'h500, 1, 32'h400, 0, 0, 0);
    chk("lock_hold_a", s_addr_o, 32'h400);
    cyc(0, 1, 32'h500, 1, 32'h400, 0, 0, 0);
    chk("lock_hold_b", s_addr_o, 32'h400);
    chk("lock_no_gnt", 32'({m1_gnt_o, m0_gnt_o}), 0);
    cyc(0, 1, 32'h500, 1, 32'h400, 1, 0, 0);
    chk("lock_gnt1", 32'({m1_gnt_o, m0_gnt_o}), 2);
    cyc(0, 1, 32'h500, 1, 32'h404, 1, 1, 32'hB1);
    chk("lock_then_gnt0", 32'({m1_gnt_o, m0_gnt_o}), 1);
    chk("lock_rvalid1", 32'(m1_rvalid_o), 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hB2);
    chk("lock_rvalid0", 32'(m0_rvalid_o), 1);

    // Full: four grants without responses, then one response frees a slot
    // only from the following cycle.
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'h600 + 32'(i), 1, 32'h700 + 32'(i), 1, 0, 0);
    cyc(0, 1, 32'h610, 1, 32'h710, 1, 0, 0);
    chk("full_no_req", 32'(s_req_o), 0);
    cyc(0, 1, 32'h610, 1, 32'h710, 1, 1, 32'hD6);
    chk("full_resp_same_cycle", 32'(s_req_o), 0);
    chk("full_resp_owner", 32'(m1_rvalid_o), 1);
    cyc(0, 1, 32'h610, 1, 32'h710, 1, 0, 0);
    chk("full_slot_freed", 32'(s_req_o), 1);
    chk("full_regrant1", 32'(m1_gnt_o), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1, 32'hE0 + 32'(i));
      if (i == 0) chk("full_drain_first", 32'(m0_rvalid_o), 1);
    end

    // Simultaneous push/pop at two outstanding: count must stay at two.
    cyc(0, 1, 32'h800, 1, 32'h900, 1, 0, 0);
    cyc(0, 1, 32'h800, 1, 32'h900, 1, 0, 0);
    cyc(0, 1, 32'h804, 0, 0, 1, 1, 32'hF0);
    chk("pushpop_gnt0", 32'(m0_gnt_o), 1);
    chk("pushpop_rvalid0", 32'(m0_rvalid_o), 1);
    cyc(0, 1, 32'h808, 1, 32'h904, 1, 0, 0);
    cyc(0, 1, 32'h808, 1, 32'h904, 1, 0, 0);
    cyc(0, 1, 32'h80C, 1, 32'h908, 1, 0, 0);
    chk("pushpop_full_after_two", 32'(s_req_o), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1, 32'hF1 + 32'(i));
      if (i == 0) chk("pushpop_order", 32'(m1_rvalid_o), 1);
    end

    // Spurious response, then reset with three outstanding.
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hDEAD);
    chk("spur_no_rvalid", 32'({m1_rvalid_o, m0_rvalid_o}), 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("spur_err_set", 32'(resp_err_o), 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'hA00, 1, 32'hB00, 1, 0, 0);
    cyc(1, 1, 32'hA00, 1, 32'hB00, 1, 1, 32'h77);
    chk("midrst_outputs", 32'({s_req_o, m1_gnt_o, m0_gnt_o, m1_rvalid_o, m0_rvalid_o}), 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_err_clr", 32'(resp_err_o), 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h78);
    chk("postrst_no_rvalid", 32'({m1_rvalid_o, m0_rvalid_o}), 0);
    cyc(0, 1, 32'hA04, 1, 32'hB04, 1, 0, 0);
    chk("postrst_ptr_port0", 32'({m1_gnt_o, m0_gnt_o}), 1);
    chk("postrst_err_set", 32'(resp_err_o), 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h79);
    chk("postrst_rvalid0", 32'(m0_rvalid_o), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
